// File: rtl/l2_refill_engine_pkg.sv
// Shared definitions for the L2 refill engine: default geometry and the
// refill sequencer state encoding (3-bit, common with lookup/controller blocks).
package l2_refill_engine_pkg;

    // Default geometry: 21-bit tag + 11-bit byte offset = 32-bit memory address.
    localparam int TAG_W_DEF    = 21;
    localparam int GROUP_W_DEF  = 4;
    localparam int OFFSET_W_DEF = 11;
    localparam int DATA_W_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB_RD  = 3'd1,
        WB_CAP = 3'd2,
        WB_WR  = 3'd3,
        FL_RD  = 3'd4,
        FL_WR  = 3'd5,
        DONE   = 3'd6
    } refill_state_t;

endpackage

// File: rtl/l2_refill_engine_if.sv
// Bus bundle of the refill engine: request/done handshake with the L2
// controller, word port of the L2 data array, and the memory word port.
// master = refill engine side, slave = controller/array/memory side.
interface l2_refill_engine_if
    import l2_refill_engine_pkg::*;
#(
    parameter int TAG_W    = TAG_W_DEF,
    parameter int GROUP_W  = GROUP_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
);
    localparam int WORD_W = OFFSET_W - 2;

    // Request handshake from the L2 controller
    logic                        req_valid;
    logic                        req_ready;
    logic [GROUP_W-1:0]          req_group;
    logic [TAG_W-1:0]            req_new_tag;
    logic [TAG_W-1:0]            req_victim_tag;
    logic                        req_victim_dirty;
    logic                        done;

    // L2 data array word port, {group,word} addressing, 1-cycle read latency
    logic [GROUP_W+WORD_W-1:0]   arr_addr;
    logic                        arr_we;
    logic [DATA_W-1:0]           arr_wdata;
    logic [DATA_W-1:0]           arr_rdata;

    // Memory word port, byte addressed, request held until ack
    logic [TAG_W+OFFSET_W-1:0]   mem_addr;
    logic                        mem_rd;
    logic                        mem_wr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        mem_ack;

    modport master (
        input  req_valid, req_group, req_new_tag, req_victim_tag, req_victim_dirty,
        output req_ready, done,
        output arr_addr, arr_we, arr_wdata,
        input  arr_rdata,
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output req_valid, req_group, req_new_tag, req_victim_tag, req_victim_dirty,
        input  req_ready, done,
        input  arr_addr, arr_we, arr_wdata,
        output arr_rdata,
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/l2_refill_stats.sv
// Refill statistics: count of completed refills and of completed victim
// write-backs. Both counters reset to zero and wrap at 2^32.
module l2_refill_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        refill_pulse,
    input  logic        writeback_pulse,
    output logic [31:0] stat_refills,
    output logic [31:0] stat_writebacks
);

    logic [1:0]  pulse;
    logic [31:0] count [2];

    assign pulse = {writeback_pulse, refill_pulse};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [31:0] count_reg;

        // Event counter, free-running wrap
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count_reg <= '0;
            end else if (pulse[gi]) begin
                count_reg <= count_reg + 32'd1;
            end
        end

        assign count[gi] = count_reg;
    end

    assign stat_refills    = count[0];
    assign stat_writebacks = count[1];

endmodule

// File: rtl/l2_refill_engine.sv
// L2 miss handler. Accepts a miss (slot, new tag, victim tag, dirty flag),
// writes a dirty victim line back to memory word by word, then fetches the
// new line from memory into the L2 data array and pulses done.
// Optional feature macro: L2_REFILL_STATS_EN adds stat_refills and
// stat_writebacks counter outputs (l2_refill_stats sub-module).
// A reset mid-refill abandons the line; the controller invalidates the slot.
module l2_refill_engine
    import l2_refill_engine_pkg::*;
#(
    parameter int TAG_W    = TAG_W_DEF,
    parameter int GROUP_W  = GROUP_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    l2_refill_engine_if.master  bus
`ifdef L2_REFILL_STATS_EN
    ,
    output logic [31:0]         stat_refills,
    output logic [31:0]         stat_writebacks
`endif
);

    localparam int WORD_W = OFFSET_W - 2;
    localparam int ARR_AW = GROUP_W + WORD_W;
    localparam int MEM_AW = TAG_W + OFFSET_W;
    localparam logic [WORD_W-1:0] LAST_IDX = '1;

    refill_state_t       state_reg;
    logic [WORD_W-1:0]   idx_reg;
    logic [WORD_W-1:0]   idx_inc;
    logic                idx_last;
    logic [GROUP_W-1:0]  group_reg;
    logic [TAG_W-1:0]    new_tag_reg;
    logic [TAG_W-1:0]    victim_tag_reg;

    logic                req_ready_reg;
    logic                done_reg;
    logic [ARR_AW-1:0]   arr_addr_reg;
    logic                arr_we_reg;
    logic [DATA_W-1:0]   arr_wdata_reg;   // doubles as the fill-data holding register
    logic [MEM_AW-1:0]   mem_addr_reg;
    logic                mem_rd_reg;
    logic                mem_wr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;   // doubles as the write-back data holding register

    // The word index only ever returns to zero through an explicit clear on the
    // last word, so the increment is never relied on to wrap.
    assign idx_inc  = idx_reg + 1'b1;
    assign idx_last = (idx_reg == LAST_IDX);

    // Refill sequencer: state, word index, latched request and all outputs.
    // Outputs are registered, so each transition sets up the outputs the next
    // state presents; reset clears them immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            group_reg      <= '0;
            new_tag_reg    <= '0;
            victim_tag_reg <= '0;
            req_ready_reg  <= 1'b1;
            done_reg       <= 1'b0;
            arr_addr_reg   <= '0;
            arr_we_reg     <= 1'b0;
            arr_wdata_reg  <= '0;
            mem_addr_reg   <= '0;
            mem_rd_reg     <= 1'b0;
            mem_wr_reg     <= 1'b0;
            mem_wdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        group_reg      <= bus.req_group;
                        new_tag_reg    <= bus.req_new_tag;
                        victim_tag_reg <= bus.req_victim_tag;
                        idx_reg        <= '0;
                        req_ready_reg  <= 1'b0;
                        if (bus.req_victim_dirty) begin
                            // Start write-back: address word 0 of the victim in the array
                            arr_addr_reg <= {bus.req_group, {WORD_W{1'b0}}};
                            state_reg    <= WB_RD;
                        end else begin
                            mem_rd_reg   <= 1'b1;
                            mem_addr_reg <= {bus.req_new_tag, {WORD_W{1'b0}}, 2'b00};
                            state_reg    <= FL_RD;
                        end
                    end
                end

                WB_RD: begin
                    state_reg <= WB_CAP;
                end

                WB_CAP: begin
                    // Array data for the word addressed in WB_RD is valid now
                    mem_wdata_reg <= bus.arr_rdata;
                    mem_addr_reg  <= {victim_tag_reg, idx_reg, 2'b00};
                    mem_wr_reg    <= 1'b1;
                    state_reg     <= WB_WR;
                end

                WB_WR: begin
                    if (bus.mem_ack) begin
                        mem_wr_reg <= 1'b0;
                        if (idx_last) begin
                            idx_reg      <= '0;
                            mem_rd_reg   <= 1'b1;
                            mem_addr_reg <= {new_tag_reg, {WORD_W{1'b0}}, 2'b00};
                            state_reg    <= FL_RD;
                        end else begin
                            idx_reg      <= idx_inc;
                            arr_addr_reg <= {group_reg, idx_inc};
                            state_reg    <= WB_RD;
                        end
                    end
                end

                FL_RD: begin
                    if (bus.mem_ack) begin
                        mem_rd_reg    <= 1'b0;
                        arr_wdata_reg <= bus.mem_rdata;
                        arr_addr_reg  <= {group_reg, idx_reg};
                        arr_we_reg    <= 1'b1;
                        state_reg     <= FL_WR;
                    end
                end

                FL_WR: begin
                    arr_we_reg <= 1'b0;
                    if (idx_last) begin
                        idx_reg   <= '0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg      <= idx_inc;
                        mem_rd_reg   <= 1'b1;
                        mem_addr_reg <= {new_tag_reg, idx_inc, 2'b00};
                        state_reg    <= FL_RD;
                    end
                end

                DONE: begin
                    done_reg      <= 1'b0;
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end

                default: begin
                    // Unused encoding: fall back to a quiet idle
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    done_reg      <= 1'b0;
                    arr_we_reg    <= 1'b0;
                    mem_rd_reg    <= 1'b0;
                    mem_wr_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.done      = done_reg;
    assign bus.arr_addr  = arr_addr_reg;
    assign bus.arr_we    = arr_we_reg;
    assign bus.arr_wdata = arr_wdata_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_rd    = mem_rd_reg;
    assign bus.mem_wr    = mem_wr_reg;
    assign bus.mem_wdata = mem_wdata_reg;

`ifdef L2_REFILL_STATS_EN
    logic writeback_pulse;

    // One write-back completes when the last victim word is acknowledged
    assign writeback_pulse = (state_reg == WB_WR) && bus.mem_ack && idx_last;

    l2_refill_stats u_stats (
        .clk             (clk),
        .reset           (reset),
        .refill_pulse    (done_reg),
        .writeback_pulse (writeback_pulse),
        .stat_refills    (stat_refills),
        .stat_writebacks (stat_writebacks)
    );
`endif

endmodule
